// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared constants for the 8x8 bicolour matrix scanner: pattern ids, requester
// indices, controller state encoding, and small helpers used by top and ROM.
package matrix_scan_ctrl_pkg;

   localparam logic [1:0] PAT_BLANK  = 2'd0;
   localparam logic [1:0] PAT_OPEN   = 2'd1;
   localparam logic [1:0] PAT_LOCKED = 2'd2;
   localparam logic [1:0] PAT_ALARM  = 2'd3;

   localparam int REQ_DIGIT  = 0;
   localparam int REQ_STATUS = 1;
   localparam int REQ_ALARM  = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_SWITCH = 2'd2
   } state_t;

   // Highest-priority set request as one-hot; alarm beats status beats digit.
   function automatic logic [2:0] top_req(input logic [2:0] r);
      logic [2:0] oh;
      oh = 3'b000;
      if (r[REQ_ALARM])       oh[REQ_ALARM]  = 1'b1;
      else if (r[REQ_STATUS]) oh[REQ_STATUS] = 1'b1;
      else if (r[REQ_DIGIT])  oh[REQ_DIGIT]  = 1'b1;
      return oh;
   endfunction

   function automatic logic [7:0] padlock_row(input logic [2:0] idx);
      logic [7:0] bits;
      case (idx)
         3'd0:    bits = 8'h3C;
         3'd1:    bits = 8'h42;
         3'd2:    bits = 8'h42;
         3'd3:    bits = 8'hFF;
         3'd4:    bits = 8'hFF;
         3'd5:    bits = 8'hE7;
         3'd6:    bits = 8'hE7;
         default: bits = 8'hFF;
      endcase
      return bits;
   endfunction

endpackage

// File: rtl/matrix_scan_ctrl_pattern_rom.sv
// Combinational column ROM: pattern id + row index -> red/green column bits.
// open = red X, locked = green padlock, alarm = solid red, blank = dark.
module pattern_rom
   import matrix_scan_ctrl_pkg::*;
(
   input  logic [1:0] pat,
   input  logic [2:0] row_idx,
   output logic [7:0] col_r,
   output logic [7:0] col_g
);

   always_comb begin
      col_r = 8'h00;
      col_g = 8'h00;
      case (pat)
         PAT_OPEN:   col_r = (8'd1 << row_idx) | (8'd1 << (3'd7 - row_idx));
         PAT_LOCKED: col_g = padlock_row(row_idx);
         PAT_ALARM:  col_r = 8'hFF;
         default:    ;
      endcase
   end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-multiplexed matrix scanner arbitrating three prioritised display owners at frame edges.
// Row/column outputs lag row_idx by one clk; MATRIX_ALARM_BLINK_EN blinks the alarm pattern.
module matrix_scan_ctrl
   import matrix_scan_ctrl_pkg::*;
#(
   parameter int CLK_DIV_PERIOD = 5000,
   parameter int MIN_FRAMES     = 4,
   parameter int BLINK_FRAMES   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
   input  logic [1:0] pat0,
   input  logic [1:0] pat1,
   input  logic [1:0] pat2,
   output logic [2:0] grant,
   output logic       frame_done,
   output logic [7:0] row,
   output logic [7:0] col_r,
   output logic [7:0] col_g
);

   localparam int CW = (CLK_DIV_PERIOD > 1) ? $clog2(CLK_DIV_PERIOD) : 1;
   localparam int DW = (MIN_FRAMES > 0) ? $clog2(MIN_FRAMES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV_PERIOD - 1);
   localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_FRAMES);

   logic [CW-1:0] cnt;
   logic [2:0]    row_idx;
   logic          tick;

   state_t        state, state_nx;
   logic [2:0]    owner, owner_nx;
   logic [DW-1:0] dwell, dwell_nx;
   logic [1:0]    pat_q, pat_nx;
   logic [1:0]    pat_sel;
   logic [2:0]    others;
   logic [7:0]    rom_r, rom_g;
   logic          lit;

   assign tick       = (cnt == CNT_LAST);
   assign frame_done = tick && (row_idx == 3'd7);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         row_idx <= 3'd0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) row_idx <= row_idx + 3'd1;
      end
   end

   assign pat_sel = owner[REQ_ALARM]  ? pat2 :
                    owner[REQ_STATUS] ? pat1 : pat0;
   assign others  = req & ~owner;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         owner <= 3'b000;
         dwell <= '0;
         pat_q <= PAT_BLANK;
      end else begin
         state <= state_nx;
         owner <= owner_nx;
         dwell <= dwell_nx;
         pat_q <= pat_nx;
      end
   end

   // owner holds the target through SWITCH; grant only exposes it once in SCAN.
   // Lower-priority takeover needs dwell already at MIN_FRAMES before this frame edge.
   always_comb begin
      state_nx = state;
      owner_nx = owner;
      dwell_nx = dwell;
      pat_nx   = pat_q;
      case (state)
         ST_IDLE: begin
            if (frame_done && (req != 3'b000)) begin
               state_nx = ST_SWITCH;
               owner_nx = top_req(req);
            end
         end
         ST_SWITCH: begin
            if (tick) begin
               state_nx = ST_SCAN;
               dwell_nx = '0;
               pat_nx   = pat_sel;
            end
         end
         ST_SCAN: begin
            if (frame_done) begin
               if ((req & owner) == 3'b000) begin
                  if (req != 3'b000) begin
                     state_nx = ST_SWITCH;
                     owner_nx = top_req(req);
                  end else begin
                     state_nx = ST_IDLE;
                     owner_nx = 3'b000;
                  end
               end else if ((others > owner) || ((others != 3'b000) && (dwell == DWELL_MAX))) begin
                  state_nx = ST_SWITCH;
                  owner_nx = top_req(others);
               end else begin
                  if (dwell != DWELL_MAX) dwell_nx = dwell + 1'b1;
                  pat_nx = pat_sel;
               end
            end
         end
         default: begin
            state_nx = ST_IDLE;
            owner_nx = 3'b000;
         end
      endcase
   end

`ifdef MATRIX_ALARM_BLINK_EN
   localparam int BW = (2 * BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_FRAMES - 1);
   localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_FRAMES);
   logic [BW-1:0] blink;

   always_ff @(posedge clk) begin
      if (rst)
         blink <= '0;
      else if ((state == ST_SWITCH) && tick)
         blink <= '0;
      else if ((state == ST_SCAN) && frame_done)
         blink <= (blink == BLINK_LAST) ? '0 : blink + 1'b1;
   end

   assign lit = (pat_q != PAT_ALARM) || (blink < BLINK_HALF);
`else
   assign lit = 1'b1;
`endif

   pattern_rom u_rom (
      .pat     (pat_q),
      .row_idx (row_idx),
      .col_r   (rom_r),
      .col_g   (rom_g)
   );

   always_ff @(posedge clk) begin
      if (rst || (state != ST_SCAN) || !lit) begin
         row   <= 8'hFF;
         col_r <= 8'h00;
         col_g <= 8'h00;
      end else begin
         row   <= ~(8'd1 << row_idx);
         col_r <= rom_r;
         col_g <= rom_g;
      end
   end

   assign grant = (state == ST_SCAN) ? owner : 3'b000;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed table-driven bench for matrix_scan_ctrl (4 clk per row slot, 32 clk per frame).
// Times are counted in clk edges since reset release; outputs are checked on the falling edge.
module tb_matrix_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] req;
   logic [1:0] pat0, pat1, pat2;
   logic [2:0] grant;
   logic       frame_done;
   logic [7:0] row, col_r, col_g;

   int kc = 0;
   int n_vec = 0;
   int n_miss = 0;

   typedef struct {
      int         k;
      bit         drive;
      logic [2:0] rq;
      logic [1:0] p0, p1, p2;
      logic [3:0] m;
      logic [2:0] g;
      logic [7:0] r, cr, cg;
      logic       fd;
   } vec_t;

   vec_t tbl[$];

   localparam logic [3:0] M_G   = 4'b0001;
   localparam logic [3:0] M_F   = 4'b1000;
   localparam logic [3:0] M_GR  = 4'b0011;
   localparam logic [3:0] M_GRC = 4'b0111;
   localparam logic [3:0] M_GF  = 4'b1001;
   localparam logic [3:0] M_ALL = 4'b1111;

   matrix_scan_ctrl #(
      .CLK_DIV_PERIOD (4),
      .MIN_FRAMES     (2),
      .BLINK_FRAMES   (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .pat0       (pat0),
      .pat1       (pat1),
      .pat2       (pat2),
      .grant      (grant),
      .frame_done (frame_done),
      .row        (row),
      .col_r      (col_r),
      .col_g      (col_g)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) kc <= 0;
      else     kc <= kc + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, kc=%0d", kc);
      $fatal(1, "watchdog");
   end

   task automatic drv(input int k, input logic [2:0] rq, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] c);
      vec_t v;
      v.k = k; v.drive = 1'b1; v.rq = rq; v.p0 = a; v.p1 = b; v.p2 = c;
      v.m = 4'b0000; v.g = 3'b000; v.r = 8'h00; v.cr = 8'h00; v.cg = 8'h00; v.fd = 1'b0;
      tbl.push_back(v);
   endtask

   task automatic chk(input int k, input logic [3:0] m, input logic [2:0] g, input logic [7:0] r,
                      input logic [7:0] cr, input logic [7:0] cg, input logic fd);
      vec_t v;
      v.k = k; v.drive = 1'b0; v.rq = 3'b000; v.p0 = 2'd0; v.p1 = 2'd0; v.p2 = 2'd0;
      v.m = m; v.g = g; v.r = r; v.cr = cr; v.cg = cg; v.fd = fd;
      tbl.push_back(v);
   endtask

   task automatic compare(input string name, input logic [3:0] m, input logic [2:0] g,
                          input logic [7:0] r, input logic [7:0] cr, input logic [7:0] cg,
                          input logic fd);
      bit bad;
      bad = 1'b0;
      n_vec++;
      if (m[0] && (grant !== g))                        bad = 1'b1;
      if (m[1] && (row !== r))                          bad = 1'b1;
      if (m[2] && ((col_r !== cr) || (col_g !== cg)))   bad = 1'b1;
      if (m[3] && (frame_done !== fd))                  bad = 1'b1;
      if (bad) begin
         n_miss++;
         $display("FAIL %s: got grant=%b row=%h col_r=%h col_g=%h fd=%b; want grant=%b row=%h col_r=%h col_g=%h fd=%b (mask %b)",
                  name, grant, row, col_r, col_g, frame_done, g, r, cr, cg, fd, m);
      end
   endtask

   task automatic goto(input int k);
      while (kc < k) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; req = 3'b000; pat0 = 2'd0; pat1 = 2'd0; pat2 = 2'd0;

      // idle after reset, frame pulses every 32 clk
      chk( 10, M_ALL, 3'b000, 8'hFF, 8'h00, 8'h00, 1'b0);
      chk( 30, M_F,   3'b000, 8'hFF, 8'h00, 8'h00, 1'b0);
      chk( 31, M_F,   3'b000, 8'hFF, 8'h00, 8'h00, 1'b1);
      chk( 32, M_F,   3'b000, 8'hFF, 8'h00, 8'h00, 1'b0);
      chk( 63, M_ALL, 3'b000, 8'hFF, 8'h00, 8'h00, 1'b1);
      chk( 95, M_ALL, 3'b000, 8'hFF, 8'h00, 8'h00, 1'b1);
      // status request: blank slot 128..131, scan from 132
      drv(100, 3'b010, 2'd1, 2'd2, 2'd3);
      chk(129, M_GRC, 3'b000, 8'hFF, 8'h00, 8'h00, 1'b0);
      chk(131, M_G,   3'b000, 8'hFF, 8'h00, 8'h00, 1'b0);
      chk(132, M_GR,  3'b010, 8'hFF, 8'h00, 8'h00, 1'b0);
      chk(133, M_GRC, 3'b010, 8'hFD, 8'h00, 8'h42, 1'b0);
      chk(137, M_GRC, 3'b010, 8'hFB, 8'h00, 8'h42, 1'b0);
      chk(141, M_GRC, 3'b010, 8'hF7, 8'h00, 8'hFF, 1'b0);
      chk(157, M_GRC, 3'b010, 8'h7F, 8'h00, 8'hFF, 1'b0);
      chk(159, M_GF,  3'b010, 8'h00, 8'h00, 8'h00, 1'b1);
      chk(161, M_GRC, 3'b010, 8'hFE, 8'h00, 8'h3C, 1'b0);
      // lower-priority digit waits for dwell
      drv(162, 3'b011, 2'd1, 2'd2, 2'd3);
      chk(193, M_GRC, 3'b010, 8'hFE, 8'h00, 8'h3C, 1'b0);
      chk(223, M_G,   3'b010, 8'h00, 8'h00, 8'h00, 1'b0);
      chk(224, M_GRC, 3'b000, 8'h7F, 8'h00, 8'hFF, 1'b0);
      chk(225, M_GRC, 3'b000, 8'hFF, 8'h00, 8'h00, 1'b0);
      chk(228, M_GR,  3'b001, 8'hFF, 8'h00, 8'h00, 1'b0);
      chk(229, M_GRC, 3'b001, 8'hFD, 8'h42, 8'h00, 1'b0);
      drv(230, 3'b001, 2'd1, 2'd2, 2'd3);
      // alarm rises mid-frame, preempts at the frame edge only
      drv(240, 3'b101, 2'd1, 2'd2, 2'd3);
      chk(250, M_GRC, 3'b001, 8'hBF, 8'h42, 8'h00, 1'b0);
      chk(255, M_G,   3'b001, 8'h00, 8'h00, 8'h00, 1'b0);
      chk(256, M_G,   3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
      chk(260, M_GR,  3'b100, 8'hFF, 8'h00, 8'h00, 1'b0);
      chk(261, M_GRC, 3'b100, 8'hFD, 8'hFF, 8'h00, 1'b0);
      drv(262, 3'b100, 2'd1, 2'd2, 2'd3);
      chk(289, M_GRC, 3'b100, 8'hFE, 8'hFF, 8'h00, 1'b0);
`ifdef MATRIX_ALARM_BLINK_EN
      chk(330, M_GRC, 3'b100, 8'hFF, 8'h00, 8'h00, 1'b0);
      chk(362, M_GRC, 3'b100, 8'hFF, 8'h00, 8'h00, 1'b0);
`else
      chk(330, M_GRC, 3'b100, 8'hFB, 8'hFF, 8'h00, 1'b0);
      chk(362, M_GRC, 3'b100, 8'hFB, 8'hFF, 8'h00, 1'b0);
`endif
      chk(390, M_GRC, 3'b100, 8'hFD, 8'hFF, 8'h00, 1'b0);
      // owner drops with nobody waiting -> idle
      drv(392, 3'b000, 2'd1, 2'd2, 2'd3);
      chk(415, M_GF,  3'b100, 8'h00, 8'h00, 8'h00, 1'b1);
      chk(416, M_GRC, 3'b000, 8'h7F, 8'hFF, 8'h00, 1'b0);
      chk(417, M_GRC, 3'b000, 8'hFF, 8'h00, 8'h00, 1'b0);
      // blank-pattern digit owner, then release + two higher requests together
      drv(420, 3'b001, 2'd0, 2'd2, 2'd3);
      chk(452, M_G,   3'b001, 8'h00, 8'h00, 8'h00, 1'b0);
      chk(457, M_GRC, 3'b001, 8'hFB, 8'h00, 8'h00, 1'b0);
      drv(460, 3'b110, 2'd0, 2'd2, 2'd3);
      chk(479, M_G,   3'b001, 8'h00, 8'h00, 8'h00, 1'b0);
      chk(480, M_G,   3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
      chk(484, M_G,   3'b100, 8'h00, 8'h00, 8'h00, 1'b0);
      // owner pattern changes mid-frame, shown from the next frame
      drv(490, 3'b110, 2'd0, 2'd2, 2'd1);
      chk(500, M_GRC, 3'b100, 8'hEF, 8'hFF, 8'h00, 1'b0);
      chk(513, M_GRC, 3'b100, 8'hFE, 8'h81, 8'h00, 1'b0);

      repeat (3) @(negedge clk);
      compare("reset_state", M_ALL, 3'b000, 8'hFF, 8'h00, 8'h00, 1'b0);
      rst = 1'b0;

      foreach (tbl[i]) begin
         goto(tbl[i].k);
         if (tbl[i].drive) begin
            req  = tbl[i].rq;
            pat0 = tbl[i].p0;
            pat1 = tbl[i].p1;
            pat2 = tbl[i].p2;
         end else begin
            compare($sformatf("vec k=%0d", tbl[i].k), tbl[i].m, tbl[i].g, tbl[i].r,
                    tbl[i].cr, tbl[i].cg, tbl[i].fd);
         end
      end

      // reset in the middle of an alarm scan
      goto(520);
      rst = 1'b1;
      @(negedge clk);
      compare("mid_frame_reset", M_ALL, 3'b000, 8'hFF, 8'h00, 8'h00, 1'b0);
      rst = 1'b0;
      goto(30);
      compare("post_reset_fd_k30", M_ALL, 3'b000, 8'hFF, 8'h00, 8'h00, 1'b0);
      goto(31);
      compare("post_reset_fd_k31", M_F, 3'b000, 8'hFF, 8'h00, 8'h00, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
